// File: rtl/rv32i_types.sv
// Shared RV32I types for the pipeline front end: machine word, major opcodes,
// and the instruction-fetch state encoding.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    // FETCH: request outstanding or about to be, response goes straight through.
    // HOLD : IF/ID stalled, the accepted instruction is replayed from inst_q.
    // DROP : a redirect arrived while a request was in flight; swallow its response.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        DROP  = 2'b10
    } fetch_state_t;

    localparam rv32i_word PC_STEP = 32'd4;

    // Instruction addresses are word aligned; low two bits are forced to zero.
    function automatic rv32i_word align_pc(input rv32i_word addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// read in flight, and presents each returned word to IF/ID with its PC, PC+4
// and branch/jump predecode. Stale responses after a redirect are discarded.
module if_fetch_stage
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h4000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        valid_if,
    output logic [31:0] pc_out_if,
    output logic [31:0] pc_plus4_if,
    output logic [31:0] inst_rdata,
    output logic        is_branch_if,
    output logic        is_jump_if
);

    fetch_state_t fstate_reg, fstate_next;
    rv32i_word    pc_q, pc_next;
    rv32i_word    tgt_q, tgt_next;
    rv32i_word    inst_q, inst_next;

    rv32i_word    redirect_target;
    rv32i_word    pc_incr;
    rv32i_word    presented_inst;
    logic [6:0]   presented_opcode;

    assign redirect_target = align_pc(redirect_pc_i);
    // Natural 32-bit overflow gives the FFFF_FFFC -> 0 wrap.
    assign pc_incr         = pc_q + PC_STEP;

    // State register: every architectural register of the stage lives here.
    always_ff @(posedge clk) begin
        if (rst) begin
            fstate_reg <= FETCH;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            inst_q     <= '0;
        end else begin
            fstate_reg <= fstate_next;
            pc_q       <= pc_next;
            tgt_q      <= tgt_next;
            inst_q     <= inst_next;
        end
    end

    // Next-state and PC selection; priority is redirect > response > stall.
    always_comb begin
        fstate_next = fstate_reg;
        pc_next     = pc_q;
        tgt_next    = tgt_q;
        inst_next   = inst_q;
        unique case (fstate_reg)
            FETCH: begin
                if (redirect_i) begin
                    if (imem_resp) begin
                        // Response arrived with the redirect: just drop it and refetch.
                        pc_next = redirect_target;
                    end else begin
                        // Request still in flight; its address must stay put until it returns.
                        tgt_next    = redirect_target;
                        fstate_next = DROP;
                    end
                end else if (imem_resp) begin
                    if (stall_i) begin
                        inst_next   = imem_rdata;
                        fstate_next = HOLD;
                    end else begin
                        pc_next = pc_incr;
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_next     = redirect_target;
                    fstate_next = FETCH;
                end else if (!stall_i) begin
                    pc_next     = pc_incr;
                    fstate_next = FETCH;
                end
            end
            DROP: begin
                if (imem_resp) begin
                    // A same-cycle redirect is newer than the parked target.
                    pc_next     = redirect_i ? redirect_target : tgt_q;
                    fstate_next = FETCH;
                end else if (redirect_i) begin
                    tgt_next = redirect_target;
                end
            end
            default: begin
                fstate_next = FETCH;
            end
        endcase
    end

    // Output decode: memory request, presented instruction and predecode flags.
    always_comb begin
        valid_if = 1'b0;
        unique case (fstate_reg)
            FETCH:   valid_if = imem_resp & ~redirect_i;
            HOLD:    valid_if = ~redirect_i;
            default: valid_if = 1'b0;
        endcase
        valid_if = valid_if & ~rst;

        imem_read = (fstate_reg != HOLD) & ~rst;
        imem_addr = rst ? '0 : pc_q;

        presented_inst   = (fstate_reg == HOLD) ? inst_q : imem_rdata;
        presented_opcode = presented_inst[6:0];

        pc_out_if    = rst ? '0 : pc_q;
        pc_plus4_if  = rst ? '0 : pc_incr;
        inst_rdata   = rst ? '0 : presented_inst;
        is_branch_if = valid_if & (presented_opcode == op_br);
        is_jump_if   = valid_if & ((presented_opcode == op_jal) |
                                   (presented_opcode == op_jalr));
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a per-cycle vector table covering the
// fetch, stall, redirect, drop, wrap and reset cases, followed by a hand-written
// variable-latency memory responder sequence.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        valid_if;
    logic [31:0] pc_out_if;
    logic [31:0] pc_plus4_if;
    logic [31:0] inst_rdata;
    logic        is_branch_if;
    logic        is_jump_if;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h4000_0060)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_read     (imem_read),
        .imem_addr     (imem_addr),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .valid_if      (valid_if),
        .pc_out_if     (pc_out_if),
        .pc_plus4_if   (pc_plus4_if),
        .inst_rdata    (inst_rdata),
        .is_branch_if  (is_branch_if),
        .is_jump_if    (is_jump_if)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        resp;
        logic [31:0] rdata;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_br;
        logic        e_jmp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] I_ADDI = 32'h0000_0013;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_JALR = 32'h0000_0067;
    localparam logic [31:0] GARB   = 32'hDEAD_BEEF;

    task automatic add(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rsp, input logic [31:0] rdat,
                       input logic e_read, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_inst, input logic e_br, input logic e_jmp);
        vec_t v;
        v.rst = r; v.stall = st; v.redir = rd; v.rpc = rpc; v.resp = rsp; v.rdata = rdat;
        v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_br = e_br; v.e_jmp = e_jmp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        logic [31:0] exp_addr;
        logic [31:0] rd_word;

        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_resp = 1'b0; imem_rdata = '0;

        //   rst st rd rpc            resp rdata   | read addr          valid inst    br jmp
        // 1: reset, then back-to-back single-cycle responses
        add(1, 0, 0, 32'h0,          0, 32'h0,    0, 32'h0,          0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          0, GARB,     1, 32'h4000_0060,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          1, I_ADDI,   1, 32'h4000_0060,  1, I_ADDI, 0, 0);
        add(0, 0, 0, 32'h0,          1, I_BEQ,    1, 32'h4000_0064,  1, I_BEQ,  1, 0);
        add(0, 0, 0, 32'h0,          1, I_JAL,    1, 32'h4000_0068,  1, I_JAL,  0, 1);
        // 2: beq accepted under a 3-cycle stall, then released
        add(0, 1, 0, 32'h0,          1, I_BEQ,    1, 32'h4000_006C,  1, I_BEQ,  1, 0);
        add(0, 1, 0, 32'h0,          0, GARB,     0, 32'h4000_006C,  1, I_BEQ,  1, 0);
        add(0, 1, 0, 32'h0,          0, GARB,     0, 32'h4000_006C,  1, I_BEQ,  1, 0);
        add(0, 0, 0, 32'h0,          0, GARB,     0, 32'h4000_006C,  1, I_BEQ,  1, 0);
        add(0, 0, 0, 32'h0,          0, GARB,     1, 32'h4000_0070,  0, 32'h0,  0, 0);
        // 3: redirect two cycles ahead of a delayed response
        add(0, 0, 1, 32'h4000_1000,  0, GARB,     1, 32'h4000_0070,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          0, GARB,     1, 32'h4000_0070,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          1, I_BEQ,    1, 32'h4000_0070,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          1, I_JALR,   1, 32'h4000_1000,  1, I_JALR, 0, 1);
        // 4: two redirects while dropping, newest wins
        add(0, 0, 1, 32'h4000_2000,  0, GARB,     1, 32'h4000_1004,  0, 32'h0,  0, 0);
        add(0, 0, 1, 32'h4000_3000,  0, GARB,     1, 32'h4000_1004,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          1, I_ADDI,   1, 32'h4000_1004,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          1, I_ADDI,   1, 32'h4000_3000,  1, I_ADDI, 0, 0);
        //    redirect + resp in the same cycle while dropping, then while fetching
        add(0, 0, 1, 32'h4000_4000,  0, GARB,     1, 32'h4000_3004,  0, 32'h0,  0, 0);
        add(0, 0, 1, 32'h4000_5000,  1, I_ADDI,   1, 32'h4000_3004,  0, 32'h0,  0, 0);
        add(0, 0, 1, 32'h4000_6000,  1, I_BEQ,    1, 32'h4000_5000,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          1, I_ADDI,   1, 32'h4000_6000,  1, I_ADDI, 0, 0);
        // 5: jal held, redirect during HOLD (target low bits forced to zero)
        add(0, 1, 0, 32'h0,          1, I_JAL,    1, 32'h4000_6004,  1, I_JAL,  0, 1);
        add(0, 1, 1, 32'h4000_7002,  0, GARB,     0, 32'h4000_6004,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          0, GARB,     1, 32'h4000_7000,  0, 32'h0,  0, 0);
        //    PC wrap at the top of the address space
        add(0, 0, 1, 32'hFFFF_FFFF,  1, I_ADDI,   1, 32'h4000_7000,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          1, I_ADDI,   1, 32'hFFFF_FFFC,  1, I_ADDI, 0, 0);
        add(0, 0, 0, 32'h0,          0, GARB,     1, 32'h0000_0000,  0, 32'h0,  0, 0);
        // 6: reset while dropping (late resp ignored), then reset during a stall
        add(0, 0, 1, 32'h4000_8000,  0, GARB,     1, 32'h0000_0000,  0, 32'h0,  0, 0);
        add(1, 0, 0, 32'h0,          1, I_BEQ,    0, 32'h0,          0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          0, GARB,     1, 32'h4000_0060,  0, 32'h0,  0, 0);
        add(0, 1, 0, 32'h0,          1, I_ADDI,   1, 32'h4000_0060,  1, I_ADDI, 0, 0);
        add(0, 1, 0, 32'h0,          0, GARB,     0, 32'h4000_0060,  1, I_ADDI, 0, 0);
        add(1, 1, 0, 32'h0,          0, GARB,     0, 32'h0,          0, 32'h0,  0, 0);
        add(0, 1, 0, 32'h0,          0, GARB,     1, 32'h4000_0060,  0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,          1, I_JAL,    1, 32'h4000_0060,  1, I_JAL,  0, 1);
        add(0, 0, 0, 32'h0,          0, GARB,     1, 32'h4000_0064,  0, 32'h0,  0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; stall_i = vecs[i].stall; redirect_i = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc; imem_resp = vecs[i].resp; imem_rdata = vecs[i].rdata;
            #2;
            chk("imem_read", i, {31'b0, imem_read}, {31'b0, vecs[i].e_read});
            chk("valid_if",  i, {31'b0, valid_if},  {31'b0, vecs[i].e_valid});
            chk("is_branch", i, {31'b0, is_branch_if}, {31'b0, vecs[i].e_br});
            chk("is_jump",   i, {31'b0, is_jump_if},   {31'b0, vecs[i].e_jmp});
            chk("imem_addr", i, imem_addr, vecs[i].e_addr);
            chk("pc_out",    i, pc_out_if, vecs[i].e_addr);
            chk("pc_plus4",  i, pc_plus4_if, vecs[i].rst ? 32'h0 : vecs[i].e_addr + 32'd4);
            if (vecs[i].e_valid || vecs[i].rst)
                chk("inst_rdata", i, inst_rdata, vecs[i].e_inst);
            $display("vec %0d: read=%0b addr=%h valid=%0b inst=%h br=%0b jmp=%0b",
                     i, imem_read, imem_addr, valid_if, inst_rdata, is_branch_if, is_jump_if);
        end

        // Variable-latency responder: 0..2 wait cycles, addresses must advance by 4.
        @(negedge clk);
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; imem_resp = 1'b0; imem_rdata = GARB;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_addr = 32'h4000_0060 + 32'(k) * 32'd4;
            rd_word  = I_ADDI | (32'(k) << 7);
            #2;
            wait_cnt = 0;
            while (!imem_read && wait_cnt < 20) begin
                @(negedge clk);
                #2;
                wait_cnt++;
            end
            chk("req_issued", 100 + k, {31'b0, imem_read}, 32'h1);
            chk("req_addr",   100 + k, imem_addr, exp_addr);
            for (int d = 0; d < k % 3; d++) begin
                @(negedge clk);
                #2;
                chk("addr_stable", 100 + k, imem_addr, exp_addr);
                chk("no_valid",    100 + k, {31'b0, valid_if}, 32'h0);
            end
            @(negedge clk);
            imem_resp = 1'b1; imem_rdata = rd_word;
            #2;
            chk("resp_valid", 100 + k, {31'b0, valid_if}, 32'h1);
            chk("resp_inst",  100 + k, inst_rdata, rd_word);
            chk("resp_pc",    100 + k, pc_out_if, exp_addr);
            $display("fetch %0d: addr=%h latency=%0d inst=%h valid=%0b",
                     k, imem_addr, k % 3 + 1, inst_rdata, valid_if);
            @(negedge clk);
            imem_resp = 1'b0; imem_rdata = GARB;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
